// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone command master.
//   wb_state_e : transaction FSM states
//   WB_SEL_ALL : all-ones byte-select source, sliced to DW/8 by users
//   cnt_width  : bits needed to count 0..TIMEOUT
package wb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StRsp
  } wb_state_e;

  localparam logic [63:0] WB_SEL_ALL = '1;

  function automatic int unsigned cnt_width(input int unsigned timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Bus timeout counter.
//   clk_i     : clock
//   rst_ni    : asynchronous active-low reset
//   clr_i     : synchronous clear (takes priority over en_i)
//   en_i      : count one cycle
//   expired_o : high during the TIMEOUT-th enabled cycle since clear, so the
//               caller can act on the same edge the count reaches TIMEOUT
module wb_timeout_cnt
  import wb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CntLast = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CntMax  = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != CntMax)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && (cnt_q == CntLast);

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone pipelined-mode initiator: one command in, one bus transaction,
// one response out. Only one transaction is ever outstanding.
//   clk, reset_n              : clock, asynchronous active-low reset
//   i_cmd_* / o_cmd_ready     : command port (valid/ready)
//   o_rsp_* / i_rsp_ready     : response port (valid/ready), err = timeout
//   o_wb_* / i_wb_*           : Wishbone master interface
module wb_cmd_master
  import wb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic            i_cmd_we,
  input  logic [AW-1:0]   i_cmd_addr,
  input  logic [DW-1:0]   i_cmd_data,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [DW-1:0]   o_rsp_data,
  output logic            o_rsp_err,
  output logic            o_wb_cyc,
  output logic            o_wb_stb,
  output logic            o_wb_we,
  output logic [DW/8-1:0] o_wb_sel,
  output logic [AW-1:0]   o_wb_addr,
  output logic [DW-1:0]   o_wb_data,
  input  logic            i_wb_ack,
  input  logic            i_wb_stall,
  input  logic [DW-1:0]   i_wb_data
);

  wb_state_e state_q, state_d;

  logic          cyc_q, cyc_d;
  logic          stb_q, stb_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_err_q, rsp_err_d;
  logic [DW-1:0] rsp_data_q, rsp_data_d;

  logic cnt_clr, cnt_en, expired;

  // Ack only counts once the strobe has been taken (stall low); a stalled
  // ack is a slave protocol error and is dropped.
  logic req_ack;
  assign req_ack = !i_wb_stall && i_wb_ack;

  wb_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout_cnt (
    .clk_i     (clk),
    .rst_ni    (reset_n),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .expired_o (expired)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      stb_q       <= stb_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  // Next-state logic. Ack beats an expiry on the same edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (i_cmd_valid) state_d = StReq;
      StReq: begin
        if (req_ack || expired) state_d = StRsp;
        else if (!i_wb_stall)   state_d = StWait;
      end
      StWait: if (i_wb_ack || expired) state_d = StRsp;
      StRsp:  if (i_rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Registered outputs and counter control.
  always_comb begin
    cyc_d       = cyc_q;
    stb_d       = stb_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_data_d  = rsp_data_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (i_cmd_valid) begin
          we_d    = i_cmd_we;
          addr_d  = i_cmd_addr;
          wdata_d = i_cmd_data;
          cyc_d   = 1'b1;
          stb_d   = 1'b1;
          cnt_clr = 1'b1;
        end
      end
      StReq, StWait: begin
        cnt_en = 1'b1;
        if (state_q == StReq && !i_wb_stall) stb_d = 1'b0;
        if ((state_q == StReq) ? req_ack : i_wb_ack) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_data_d  = we_q ? '0 : i_wb_data;
        end else if (expired) begin
          cyc_d       = 1'b0;
          stb_d       = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_data_d  = '0;
        end
      end
      StRsp: begin
        if (i_rsp_ready) rsp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Held low during reset so nothing is offered as accepted before release.
  assign o_cmd_ready = (state_q == StIdle) && reset_n;

  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;
  assign o_wb_cyc    = cyc_q;
  assign o_wb_stb    = stb_q;
  assign o_wb_we     = we_q;
  assign o_wb_sel    = WB_SEL_ALL[DW/8-1:0];
  assign o_wb_addr   = addr_q;
  assign o_wb_data   = wdata_q;

endmodule

// File: doc/wb_cmd_master.md
Name: wb_cmd_master

Overview:
- Wishbone initiator that turns single commands on a valid/ready port into one Wishbone pipelined-mode transaction each. It is the counterpart of the team's Wishbone slave peripherals, such as the buttons/LEDs block.
- Used by test harnesses and by user-area sequencers to read and write peripheral registers.
- Only one transaction is outstanding at a time.
- Every transaction returns a response carrying read data or an error flag on a bus timeout.

Parameters:
- AW, 32, address width.
- DW, 32, data width (multiple of 8).
- TIMEOUT, 255, max cycles from stb assertion to ack before abort (≥1).

Ports:
- clk  in  1  single clock, all logic rising-edge.
- reset_n  in  1  reset, asynchronous, active-low.
- i_cmd_valid  in  1  command present.
- o_cmd_ready  out  1  command accepted when valid&&ready.
- i_cmd_we  in  1  1=write, 0=read.
- i_cmd_addr  in  AW  target address.
- i_cmd_data  in  DW  write data (ignored for reads).
- o_rsp_valid  out  1  response present.
- i_rsp_ready  in  1  response consumed when valid&&ready.
- o_rsp_data  out  DW  read data; 0 for writes and errors.
- o_rsp_err  out  1  1=timeout abort.
- o_wb_cyc  out  1  bus cycle.
- o_wb_stb  out  1  request strobe.
- o_wb_we  out  1  write enable.
- o_wb_sel  out  DW/8  byte selects, always all ones.
- o_wb_addr  out  AW  address.
- o_wb_data  out  DW  write data.
- i_wb_ack  in  1  slave completion.
- i_wb_stall  in  1  slave not accepting stb.
- i_wb_data  in  DW  read data, valid with ack.

Behaviour:
- Reset (reset_n low, async):
  - State IDLE.
  - o_wb_cyc, o_wb_stb, o_wb_we, o_rsp_valid and o_rsp_err are 0.
  - o_wb_addr, o_wb_data and o_rsp_data are 0.
  - o_cmd_ready is 0 while reset is asserted and 1 on the first cycle after release.
  - Reset during a transaction drops cyc/stb immediately; there is no response and the command is lost.
- All outputs are registered except o_cmd_ready, which equals (state==IDLE).
- States:
  - IDLE:
    - o_cmd_ready=1.
    - On valid&&ready at edge N: latch we/addr/data and drive o_wb_* from these registers.
    - Set cyc=stb=1 from cycle N+1; clear the timeout counter; go to REQ.
  - REQ:
    - stb held high while i_wb_stall=1.
    - On an edge where stall=0, stb drops next cycle and cyc stays high.
    - If ack and !stall arrive together: complete directly and go to RSP.
    - Otherwise go to WAIT.
  - WAIT:
    - cyc=1, stb=0.
    - On ack: capture i_wb_data (reads) or 0 (writes) into o_rsp_data, set err=0, drop cyc, go to RSP.
  - RSP:
    - o_rsp_valid=1; data and err held stable.
    - On valid&&ready: o_rsp_valid=0 next cycle, go to IDLE.
- Timeout:
  - The counter increments every cycle in REQ/WAIT.
  - When it reaches TIMEOUT with no ack: drop cyc/stb, set rsp_err=1 and rsp_data=0, go to RSP.
  - Ack on the same edge as expiry: ack wins, err=0.
- Ignored inputs:
  - ack in IDLE or RSP (stray) is ignored.
  - ack while stb is still stalled in REQ is treated as a protocol error and ignored; stall rules the REQ state.
- Latency:
  - Minimum is command accept edge N, stb at N+1, ack at N+1, rsp_valid at N+2.
  - Back-to-back throughput is one transaction per ≥3 cycles (IDLE→REQ→RSP→IDLE).
- Backpressure: a command is never accepted while a response is unconsumed.
- Address is word-granular as delivered; this block does no alignment or translation.

Decomposition:
- Package wb_pkg holds:
  - the state enum (IDLE, REQ, WAIT, RSP);
  - WB_SEL_ALL;
  - the helper function computing counter width as $clog2(TIMEOUT+1).
- Sub-module wb_timeout_cnt: clear/enable/expired counter, parameterised by TIMEOUT.
- The FSM and datapath stay in wb_cmd_master.

Test Plan:
- Write, zero wait:
  - Stimulus: cmd we=1, addr=0x3000_0000, data=0x0000_0F0F at edge 0; slave acks at cycle 1.
  - Required: wb_addr/data/we match; stb high exactly 1 cycle; rsp_valid at cycle 2 with data=0, err=0.
- Read with stall and wait:
  - Stimulus: read addr=0x3000_0004; stall=1 for 3 cycles, then ack 2 cycles after acceptance with i_wb_data=0x0000_0080.
  - Required: stb held 4 cycles; rsp_data=0x80, err=0; cyc low the cycle after ack.
- Timeout:
  - Stimulus: TIMEOUT=8, read, no ack.
  - Required: cyc drops after exactly 8 cycles in REQ/WAIT; rsp_err=1, rsp_data=0; a late ack at +2 cycles is ignored.
- Response backpressure:
  - Stimulus: hold i_rsp_ready=0 for 5 cycles with a second command valid.
  - Required: o_cmd_ready=0 throughout; response stable; second command accepted the cycle after rsp handshake.
- Async reset mid-WAIT:
  - Stimulus: pulse reset_n low between edges.
  - Required: cyc/stb/rsp_valid go to 0 without a clock edge; the next command completes normally.
- Ack/timeout collision:
  - Stimulus: TIMEOUT=4, ack on the expiry cycle with i_wb_data=0xA5.
  - Required: err=0, data=0xA5.
